// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared state encoding and constants for the LED source scheduler
package led_pkg;

    localparam int LED_WIDTH     = 16;
    localparam int DEFAULT_DWELL = 10_000_000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROTATE = 2'd1,
        ST_URGENT = 2'd2
    } led_state_e;

endpackage

// File: rtl/led_source_scheduler_if.sv
// rtl/led_source_scheduler_if.sv - request/pattern inputs and LED/grant outputs of the scheduler
interface led_source_scheduler_if
    import led_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LEDW = LED_WIDTH
);

    logic [NREQ-1:0]      req;
    logic [NREQ*LEDW-1:0] pattern;
    logic                 freeze;
    logic [LEDW-1:0]      led_out;
    logic [NREQ-1:0]      grant;
    logic                 page_switch;

    modport master (
        output req, pattern, freeze,
        input  led_out, grant, page_switch
    );

    modport slave (
        input  req, pattern, freeze,
        output led_out, grant, page_switch
    );

endinterface

// File: rtl/led_rr_pick.sv
// rtl/led_rr_pick.sv - combinational round-robin picker over the non-urgent requesters
module led_rr_pick
    import led_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ),
    parameter int SW   = IW + 1
) (
    input  logic [NREQ-1:1] req,
    input  logic [SW-1:0]   start,
    output logic            found,
    output logic [IW-1:0]   idx
);

    int base;
    int cand;

    // A start of 0 or past the top index wraps to requester 1, so owner+1 can be fed directly.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        base  = (int'(start) >= 1 && int'(start) < NREQ) ? int'(start) : 1;
        for (int k = 0; k < NREQ - 1; k++) begin
            cand = base + k;
            if (cand >= NREQ) begin
                cand = cand - (NREQ - 1);
            end
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/led_source_scheduler.sv
// rtl/led_source_scheduler.sv - shares the LEDs between an urgent source and round-robin pages
module led_source_scheduler
    import led_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int LEDW  = LED_WIDTH,
    parameter int DWELL = DEFAULT_DWELL
) (
    input  logic                   clk,
    input  logic                   rst,
    led_source_scheduler_if.slave  bus
);

    localparam int IW = $clog2(NREQ);
    localparam int SW = IW + 1;
    localparam int CW = $clog2(DWELL + 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

    led_state_e      state, state_d;
    logic [IW-1:0]   owner, owner_d;
    logic [IW-1:0]   rr_ptr, rr_d;
    logic [CW-1:0]   dwell_cnt, cnt_d;
    logic [NREQ-1:0] grant_d;
    logic [LEDW-1:0] led_d;

    logic            rr_found, nx_found;
    logic [IW-1:0]   rr_idx, nx_idx;
    logic [SW-1:0]   nx_start;

    assign nx_start = {1'b0, owner} + SW'(1);

    led_rr_pick #(.NREQ(NREQ), .IW(IW), .SW(SW)) u_pick_rr (
        .req   (bus.req[NREQ-1:1]),
        .start ({1'b0, rr_ptr}),
        .found (rr_found),
        .idx   (rr_idx)
    );

    led_rr_pick #(.NREQ(NREQ), .IW(IW), .SW(SW)) u_pick_next (
        .req   (bus.req[NREQ-1:1]),
        .start (nx_start),
        .found (nx_found),
        .idx   (nx_idx)
    );

    always_comb begin
        state_d = state;
        owner_d = owner;
        rr_d    = rr_ptr;
        cnt_d   = dwell_cnt;
        case (state)
            // Leaving URGENT behaves like leaving IDLE: the preempted page is still at rr_ptr.
            ST_IDLE, ST_URGENT: begin
                cnt_d = '0;
                if (bus.req[0]) begin
                    state_d = ST_URGENT;
                    owner_d = '0;
                end else if (rr_found) begin
                    state_d = ST_ROTATE;
                    owner_d = rr_idx;
                    rr_d    = rr_idx;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ROTATE: begin
                if (bus.req[0]) begin
                    state_d = ST_URGENT;
                    owner_d = '0;
                    cnt_d   = '0;
                end else if (!bus.req[owner]) begin
                    cnt_d = '0;
                    if (nx_found) begin
                        owner_d = nx_idx;
                        rr_d    = nx_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (!bus.freeze) begin
                    if (dwell_cnt == DWELL_LAST) begin
                        // Owner is active, so the search always finds someone, possibly itself.
                        cnt_d   = '0;
                        owner_d = nx_idx;
                        rr_d    = nx_idx;
                    end else begin
                        cnt_d = dwell_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        grant_d = '0;
        led_d   = '0;
        if (state_d == ST_URGENT) begin
            grant_d[0] = 1'b1;
            led_d      = bus.pattern[0 +: LEDW];
        end else if (state_d == ST_ROTATE) begin
            grant_d[owner_d] = 1'b1;
            led_d            = bus.pattern[int'(owner_d) * LEDW +: LEDW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            owner           <= '0;
            rr_ptr          <= IW'(1);
            dwell_cnt       <= '0;
            bus.led_out     <= '0;
            bus.grant       <= '0;
            bus.page_switch <= 1'b0;
        end else begin
            state           <= state_d;
            owner           <= owner_d;
            rr_ptr          <= rr_d;
            dwell_cnt       <= cnt_d;
            bus.led_out     <= led_d;
            bus.grant       <= grant_d;
            bus.page_switch <= (grant_d != bus.grant);
        end
    end

endmodule

// File: tb/tb_led_source_scheduler.sv
// tb/tb_led_source_scheduler.sv - self-checking bench for led_source_scheduler
module tb_led_source_scheduler;

    localparam int NREQ  = 4;
    localparam int LEDW  = 16;
    localparam int DWELL = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    led_source_scheduler_if #(.NREQ(NREQ), .LEDW(LEDW)) bus ();

    led_source_scheduler #(.NREQ(NREQ), .LEDW(LEDW), .DWELL(DWELL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: owner -1 = nobody, 0 = urgent; age = whole cycles the current page has been shown.
    int              m_owner, m_rr, m_age, m_c;
    logic [NREQ-1:0] m_grant, m_gnew;
    logic [LEDW-1:0] m_led;
    logic            m_ps;

    function automatic int first_active(input logic [NREQ-1:0] r, input int from);
        int cand;
        for (int step = 0; step < NREQ - 1; step++) begin
            cand = 1 + ((from - 1 + step) % (NREQ - 1));
            if (r[cand]) return cand;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1; m_rr = 1; m_age = 0;
            m_grant = '0; m_led = '0; m_ps = 1'b0;
        end else begin
            if (bus.req[0]) begin
                m_owner = 0; m_age = 0;
            end else if (m_owner <= 0) begin
                m_c = first_active(bus.req, m_rr);
                m_owner = m_c; m_age = 0;
                if (m_c > 0) m_rr = m_c;
            end else if (!bus.req[m_owner]) begin
                m_c = first_active(bus.req, m_owner + 1);
                m_owner = m_c; m_age = 0;
                if (m_c > 0) m_rr = m_c;
            end else if (!bus.freeze) begin
                m_age++;
                if (m_age == DWELL) begin
                    m_age = 0;
                    m_owner = first_active(bus.req, m_owner + 1);
                    m_rr = m_owner;
                end
            end
            m_gnew  = (m_owner < 0) ? '0 : (NREQ'(1) << m_owner);
            m_led   = (m_owner < 0) ? '0 : bus.pattern[m_owner * LEDW +: LEDW];
            m_ps    = (m_gnew != m_grant);
            m_grant = m_gnew;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("model_grant", 32'(bus.grant), 32'(m_grant));
            check("model_led_out", 32'(bus.led_out), 32'(m_led));
            check("model_page_switch", 32'(bus.page_switch), 32'(m_ps));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int sw;
    int held;

    initial begin
        rst = 1'b1;
        bus.req = '0;
        bus.freeze = 1'b0;
        bus.pattern = {16'hC3C3, 16'h1234, 16'hA5A5, 16'hFFFF};
        tick(3);
        check("reset_grant", 32'(bus.grant), 32'h0);
        check("reset_led_out", 32'(bus.led_out), 32'h0);
        check("reset_page_switch", 32'(bus.page_switch), 32'h0);
        rst = 1'b0;
        tick(2);

        // single requester enters one edge after req
        bus.req = 4'b0010;
        tick(1);
        check("t1_grant", 32'(bus.grant), 32'h2);
        check("t1_led_out", 32'(bus.led_out), 32'hA5A5);
        check("t1_page_switch", 32'(bus.page_switch), 32'h1);
        tick(1);
        check("t1_page_switch_once", 32'(bus.page_switch), 32'h0);

        // two pages alternate every DWELL cycles
        bus.req = 4'b1010;
        tick(3);
        sw = 0;
        repeat (32) begin tick(1); if (bus.page_switch) sw++; end
        check("t2_switches_in_32", 32'(sw), 32'd4);
        bus.req = 4'b0010;
        tick(3);
        sw = 0;
        repeat (24) begin tick(1); if (bus.page_switch) sw++; end
        check("t2_single_no_switch", 32'(sw), 32'd0);
        check("t2_single_grant", 32'(bus.grant), 32'h2);

        // urgent preemption mid-dwell, then full fresh dwell on return
        bus.req = 4'b0000;
        tick(2);
        check("t3_idle_grant", 32'(bus.grant), 32'h0);
        bus.req = 4'b1010;
        tick(1);
        check("t3_entry_grant", 32'(bus.grant), 32'h2);
        tick(3);
        bus.req = 4'b1011;
        tick(1);
        check("t3_urgent_grant", 32'(bus.grant), 32'h1);
        check("t3_urgent_led", 32'(bus.led_out), 32'hFFFF);
        tick(19);
        bus.req = 4'b1010;
        held = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.grant != 4'b0010) break;
            held++;
        end
        check("t3_full_dwell", 32'(held), 32'd8);
        check("t3_next_page", 32'(bus.grant), 32'h8);

        // urgent arrives on the very cycle the dwell expires
        tick(7);
        bus.req = 4'b1011;
        tick(1);
        check("t4_preempt_wins", 32'(bus.grant), 32'h1);
        bus.req = 4'b1010;
        tick(1);
        check("t4_resume_page", 32'(bus.grant), 32'h8);

        // owner release mid-dwell moves straight to the next active
        bus.req = 4'b0000;
        tick(2);
        bus.req = 4'b0100;
        tick(1);
        check("t5_owner2", 32'(bus.grant), 32'h4);
        bus.req = 4'b1110;
        tick(2);
        bus.req = 4'b1010;
        tick(1);
        check("t5_release_grant", 32'(bus.grant), 32'h8);
        check("t5_release_led", 32'(bus.led_out), 32'hC3C3);
        bus.req = 4'b0000;
        tick(1);
        check("t5_idle_grant", 32'(bus.grant), 32'h0);
        check("t5_idle_led", 32'(bus.led_out), 32'h0);

        // freeze holds the page; reset clears outputs without a clock edge
        bus.req = 4'b1010;
        bus.freeze = 1'b1;
        tick(1);
        check("t6_freeze_entry", 32'(bus.grant), 32'h8);
        sw = 0;
        repeat (50) begin tick(1); if (bus.page_switch) sw++; end
        check("t6_freeze_no_switch", 32'(sw), 32'd0);
        check("t6_freeze_grant", 32'(bus.grant), 32'h8);
        #2 rst = 1'b1;
        #1;
        check("t6_async_grant", 32'(bus.grant), 32'h0);
        check("t6_async_led", 32'(bus.led_out), 32'h0);
        tick(2);
        bus.freeze = 1'b0;
        rst = 1'b0;
        tick(1);
        check("t6_after_reset_grant", 32'(bus.grant), 32'h2);
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
